// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - sequential instruction prefetcher with in-flight tracking and show-ahead queue
// Credit-based issue keeps queued plus in-flight reads within DEPTH, so the queue never overflows.
module inst_prefetch_queue #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect_in,
   input  logic [31:0]              redirect_pc_in,
   input  logic                     deq_in,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int DEP   = int'(DEPTH);
   localparam int LAT   = int'(MEM_LATENCY);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DEPTH + MEM_LATENCY + 1) + 1;
   localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

   logic [31:0]      fetch_pc;
   logic [LAT-1:0]   trk_valid;
   logic [31:0]      trk_pc [LAT];
   logic [31:0]      q_pc   [DEP];
   logic [31:0]      q_inst [DEP];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_next;
   logic [CNT_W-1:0] inflight_count;
   logic [CNT_W-1:0] credit_used;
   logic             pop;
   logic             enq;
   logic [31:0]      enq_pc;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight_count = inflight_count + CNT_W'(trk_valid[i]);
      end
   end

   assign out_valid   = (occupancy != '0);
   assign pop         = deq_in && out_valid;
   assign enq         = trk_valid[LAT-1];
   assign enq_pc      = trk_pc[LAT-1];
   assign head_next   = head + PTR_W'(1);
   assign credit_used = CNT_W'(occupancy) - CNT_W'(pop) + inflight_count;

   // Gated by rst_in so the request is low while reset is held.
   assign imem_req  = !rst_in && !redirect_in && (credit_used < CNT_W'(DEPTH));
   assign imem_addr = imem_req ? fetch_pc : '0;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         fetch_pc <= RESET_PC_AL;
      end else if (redirect_in) begin
         fetch_pc <= redirect_pc_in & 32'hFFFF_FFFC;
      end else if (imem_req) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         trk_valid <= '0;
         for (int i = 0; i < LAT; i++) begin
            trk_pc[i] <= '0;
         end
      end else if (redirect_in) begin
         trk_valid <= '0;
      end else begin
         trk_valid[0] <= imem_req;
         trk_pc[0]    <= imem_addr;
         for (int i = 1; i < LAT; i++) begin
            trk_valid[i] <= trk_valid[i-1];
            trk_pc[i]    <= trk_pc[i-1];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (enq && !redirect_in) begin
         q_pc[tail]   <= enq_pc;
         q_inst[tail] <= imem_rdata;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         out_pc    <= '0;
         out_inst  <= '0;
      end else if (redirect_in) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head_next;
         end
         if (enq && !pop) begin
            occupancy <= occupancy + OCC_W'(1);
         end else if (!enq && pop) begin
            occupancy <= occupancy - OCC_W'(1);
         end
         // Head register tracks whichever entry becomes the new head; holds otherwise.
         if (pop) begin
            if (occupancy > OCC_W'(1)) begin
               out_pc   <= q_pc[head_next];
               out_inst <= q_inst[head_next];
            end else if (enq) begin
               out_pc   <= enq_pc;
               out_inst <= imem_rdata;
            end
         end else if (enq && (occupancy == '0)) begin
            out_pc   <= enq_pc;
            out_inst <= imem_rdata;
         end
      end
   end

endmodule
